// File: rtl/seven_segment_mux.sv
// rtl/seven_segment_mux.sv - N-digit time-multiplexed seven-segment display driver
module seven_segment_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int HEX_MODE       = 0,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              segment,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*NUM_DIGITS-1:0] disp_bcd_q, disp_bcd_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                    pending_q, pending_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;

  logic                    terminal;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   lz_blank;

  // Active-high a..g glyph for one digit code; codes above 9 go dark unless hex is enabled
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0:    g = 7'b1111110;
      4'h1:    g = 7'b0110000;
      4'h2:    g = 7'b1101101;
      4'h3:    g = 7'b1111001;
      4'h4:    g = 7'b0110011;
      4'h5:    g = 7'b1011011;
      4'h6:    g = 7'b1011111;
      4'h7:    g = 7'b1110000;
      4'h8:    g = 7'b1111111;
      4'h9:    g = 7'b1111011;
      4'hA:    g = 7'b1110111;
      4'hB:    g = 7'b0011111;
      4'hC:    g = 7'b1001110;
      4'hD:    g = 7'b0111101;
      4'hE:    g = 7'b1001111;
      default: g = 7'b1000111;
    endcase
    if (HEX_MODE == 0 && code > 4'h9) g = 7'b0000000;
    return g;
  endfunction

  assign terminal   = (presc_q == PRESC_LAST);
  assign frame_done = enable && terminal && (idx_q == IDX_LAST);

  // Prescaler and digit index advance only while scanning is enabled
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (enable) begin
      if (terminal) begin
        presc_d = '0;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Double buffer: loads land in the shadow; the display copy only changes at frame end
  always_comb begin
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    disp_bcd_d   = disp_bcd_q;
    disp_dp_d    = disp_dp_q;
    pending_d    = pending_q;
    if (load) begin
      shadow_bcd_d = bcd_in;
      shadow_dp_d  = dp_in;
      pending_d    = 1'b1;
    end
    if (frame_done) begin
      if (load) begin
        disp_bcd_d = bcd_in;
        disp_dp_d  = dp_in;
        pending_d  = 1'b0;
      end else if (pending_q) begin
        disp_bcd_d = shadow_bcd_q;
        disp_dp_d  = shadow_dp_q;
        pending_d  = 1'b0;
      end
    end
  end

  // Digit i (i>0) is a leading zero when it and every digit above it are zero
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run    = zero_run && (disp_bcd_q[4*i +: 4] == 4'h0);
      lz_blank[i] = (i != 0) && zero_run;
    end
  end

  // Next registered outputs for the currently indexed digit, dark when disabled
  always_comb begin
    cur_code  = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    sel_d     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_code  = disp_bcd_q[4*i +: 4];
        cur_dp    = disp_dp_q[i];
        cur_blank = blank_lz && lz_blank[i];
        sel_d[i]  = enable;
      end
    end
    seg_d = (enable && !cur_blank) ? glyph(cur_code) : 7'b0000000;
    dp_d  = enable && cur_dp;
  end

  // State and output registers; reset discards everything and drives outputs off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      disp_bcd_q   <= '0;
      disp_dp_q    <= '0;
      pending_q    <= 1'b0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      sel_q        <= '0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      sel_q        <= sel_d;
    end
  end

  assign segment   = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign dp        = (SEG_ACTIVE_LOW != 0) ? ~dp_q  : dp_q;
  assign digit_sel = (DIG_ACTIVE_LOW != 0) ? ~sel_q : sel_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// tb/tb_seven_segment_mux.sv - self-checking bench for seven_segment_mux
module tb_seven_segment_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] bcd;
  logic [3:0]  dpv;
  logic        blz;

  logic [6:0] seg0, seg1, seg2;
  logic       dp0, dp1, dp2;
  logic [3:0] sel0, sel1;
  logic [0:0] sel2;
  logic       fd0, fd1, fd2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // dut0: plain decimal, active-high outputs
  seven_segment_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(0),
                      .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .bcd_in(bcd),
    .dp_in(dpv), .blank_lz(blz), .segment(seg0), .dp(dp0), .digit_sel(sel0),
    .frame_done(fd0));

  // dut1: hex glyphs, common-anode style inverted outputs
  seven_segment_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(1),
                      .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .bcd_in(bcd),
    .dp_in(dpv), .blank_lz(blz), .segment(seg1), .dp(dp1), .digit_sel(sel1),
    .frame_done(fd1));

  // dut2: single digit
  seven_segment_mux #(.NUM_DIGITS(1), .REFRESH_DIV(3), .HEX_MODE(0),
                      .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .bcd_in(bcd[3:0]),
    .dp_in(dpv[0:0]), .blank_lz(blz), .segment(seg2), .dp(dp2), .digit_sel(sel2),
    .frame_done(fd2));

  int  nd_c[3]  = '{4, 4, 1};
  int  rd_c[3]  = '{4, 4, 3};
  bit  hex_c[3] = '{1'b0, 1'b1, 1'b0};
  bit  inv_c[3] = '{1'b0, 1'b1, 1'b0};

  logic [6:0] dec_tab[10];
  logic [6:0] hex_tab[6];

  // Reference model: enabled-cycle count t locates the scan position arithmetically
  int          t_m[3];
  logic [15:0] disp_b[3], sh_b[3];
  logic [3:0]  disp_d[3], sh_d[3];
  bit          pend[3];
  logic [6:0]  exp_seg[3];
  logic        exp_dp[3];
  logic [3:0]  exp_sel[3];

  function automatic logic [6:0] mglyph(input int code, input bit hex);
    if (code < 10) return dec_tab[code];
    if (hex) return hex_tab[code - 10];
    return 7'b0000000;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s dut%0d: got %0h expected %0h", tag, k, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      t_m[k] = 0; disp_b[k] = '0; sh_b[k] = '0; disp_d[k] = '0; sh_d[k] = '0;
      pend[k] = 1'b0; exp_seg[k] = '0; exp_dp[k] = 1'b0; exp_sel[k] = '0;
    end
  endtask

  task automatic check_fd();
    logic [2:0] fds;
    fds = {fd2, fd1, fd0};
    for (int k = 0; k < 3; k++) begin
      int f;
      f = nd_c[k] * rd_c[k];
      chk("frame_done", k, {31'b0, fds[k]}, {31'b0, (enable === 1'b1) && (t_m[k] % f == f - 1)});
    end
  endtask

  task automatic check_out();
    for (int k = 0; k < 3; k++) begin
      logic [6:0] es, os;
      logic       ed, od;
      logic [3:0] esel, osel, mask;
      mask = (k == 2) ? 4'b0001 : 4'b1111;
      es   = inv_c[k] ? ~exp_seg[k] : exp_seg[k];
      ed   = inv_c[k] ? ~exp_dp[k]  : exp_dp[k];
      esel = (inv_c[k] ? ~exp_sel[k] : exp_sel[k]) & mask;
      case (k)
        0:       begin os = seg0; od = dp0; osel = sel0; end
        1:       begin os = seg1; od = dp1; osel = sel1; end
        default: begin os = seg2; od = dp2; osel = {3'b000, sel2}; end
      endcase
      chk("segment",   k, {25'b0, os},   {25'b0, es});
      chk("dp",        k, {31'b0, od},   {31'b0, ed});
      chk("digit_sel", k, {28'b0, osel}, {28'b0, esel});
    end
  endtask

  // Predict what each DUT registers on the coming edge, then advance the model
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int f, pos, i;
      logic [15:0] in_b, upper;
      logic [3:0]  in_d;
      bit fd;
      in_b = (k == 2) ? {12'b0, bcd[3:0]} : bcd;
      in_d = (k == 2) ? {3'b0, dpv[0]} : dpv;
      f   = nd_c[k] * rd_c[k];
      pos = t_m[k] % f;
      i   = pos / rd_c[k];
      fd  = enable && (pos == f - 1);
      if (enable) begin
        upper      = disp_b[k] >> (4 * i);
        exp_seg[k] = (blz && i > 0 && upper == 0) ? 7'b0 : mglyph(int'(upper & 16'hF), hex_c[k]);
        exp_dp[k]  = disp_d[k][i];
        exp_sel[k] = 4'(1 << i);
        t_m[k]++;
      end else begin
        exp_seg[k] = '0; exp_dp[k] = 1'b0; exp_sel[k] = '0;
      end
      if (fd && load) begin
        disp_b[k] = in_b; disp_d[k] = in_d; pend[k] = 1'b0;
      end else if (fd && pend[k]) begin
        disp_b[k] = sh_b[k]; disp_d[k] = sh_d[k]; pend[k] = 1'b0;
      end
      if (load) begin
        sh_b[k] = in_b; sh_d[k] = in_d;
        if (!fd) pend[k] = 1'b1;
      end
    end
  endtask

  task automatic step(input bit en, input bit ld, input logic [15:0] b, input logic [3:0] d, input bit z);
    enable = en; load = ld; bcd = b; dpv = d; blz = z;
    #1;
    check_fd();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  task automatic idle(input int n, input bit z);
    for (int j = 0; j < n; j++) step(1'b1, 1'b0, bcd, dpv, z);
  endtask

  initial begin
    dec_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    hex_tab = '{7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    rst_n = 1'b0; enable = 1'b0; load = 1'b0; bcd = '0; dpv = '0; blz = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_out();
    rst_n = 1'b1;

    // Basic scan of 1234 loaded before the first frame end
    step(1'b1, 1'b1, 16'h1234, 4'b0010, 1'b0);
    idle(40, 1'b0);

    // Leading-zero blanking
    step(1'b1, 1'b1, 16'h0007, 4'b1000, 1'b1);
    idle(20, 1'b1);
    step(1'b1, 1'b1, 16'h0000, 4'b0101, 1'b1);
    idle(20, 1'b1);

    // Hex codes
    step(1'b1, 1'b1, 16'h000A, 4'b0000, 1'b0);
    idle(20, 1'b0);
    step(1'b1, 1'b1, 16'hABCF, 4'b0000, 1'b0);
    idle(20, 1'b0);

    // Mid-frame load, then a load landing on the frame_done cycle
    step(1'b1, 1'b1, 16'h1234, 4'b0000, 1'b0);
    idle(22, 1'b0);
    step(1'b1, 1'b1, 16'h5555, 4'b0000, 1'b0);
    idle(20, 1'b0);
    while ((t_m[0] % 16) != 15) step(1'b1, 1'b0, bcd, dpv, 1'b0);
    step(1'b1, 1'b1, 16'h9876, 4'b1001, 1'b0);
    idle(18, 1'b0);

    // Pause mid-digit with a load while dark, then resume
    idle(2, 1'b0);
    for (int j = 0; j < 10; j++) step(1'b0, (j == 4), 16'h4321, 4'b0110, 1'b0);
    idle(30, 1'b0);

    // Asynchronous reset mid-frame
    idle(5, 1'b0);
    step(1'b1, 1'b1, 16'h8888, 4'b1111, 1'b0);
    idle(20, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_out();
    check_fd();
    @(negedge clk);
    rst_n = 1'b1;
    idle(10, 1'b0);

    // Randomized traffic
    for (int j = 0; j < 800; j++) begin
      logic [15:0] rb;
      rb = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      step($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, rb,
           4'($urandom), (j % 64) >= 32);
    end
    step(1'b1, 1'b0, bcd, dpv, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_mux.md
Name: seven_segment_mux

Overview:
N-digit, time-multiplexed seven-segment display driver. It is the parametrised successor of the team's single-digit BCD decoder and extends it with:
- digit scanning with a programmable refresh prescaler
- tear-free double-buffered loading
- optional hex glyphs
- leading-zero blanking
- decimal points
- selectable output polarity

It sits between the numeric datapath and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits driven; legal range 1..8.
REFRESH_DIV, 1000, clk cycles each digit stays selected; legal minimum 2.
HEX_MODE, 0, 1 = codes 10..15 show A,b,C,d,E,F; 0 = codes 10..15 blank.
SEG_ACTIVE_LOW, 0, 1 = segment and dp outputs inverted, for common-anode displays.
DIG_ACTIVE_LOW, 0, 1 = digit_sel outputs inverted.

Ports:
clk  input  1  system clock; the block uses one clock.
rst_n  input  1  asynchronous, active-low reset.
enable  input  1  1 = scanning; 0 = display dark and counters hold.
load  input  1  1-cycle strobe that captures bcd_in and dp_in into the shadow register.
bcd_in  input  4*NUM_DIGITS  digit codes; bits [3:0] are digit 0 (rightmost).
dp_in  input  NUM_DIGITS  decimal point per digit; bit i is digit i.
blank_lz  input  1  1 = blank leading zeros.
segment  output  7  segments a..g, bit6 = a through bit0 = g; registered.
dp  output  1  decimal point of the selected digit; registered.
digit_sel  output  NUM_DIGITS  one-hot digit enable; registered.
frame_done  output  1  1-cycle pulse at the end of every scan frame.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - prescaler=0, index=0, shadow=0, display=0, pending=0, frame_done=0.
  - segment and dp are at the OFF level: 0, or all-1 if SEG_ACTIVE_LOW.
  - digit_sel is all inactive.
  - Reset mid-frame or mid-load discards all state.
- Prescaler counts 0..REFRESH_DIV-1 while enable=1.
  - At terminal count it returns to 0 and index advances.
  - index wraps from NUM_DIGITS-1 to 0.
- frame_done = 1 for exactly the cycle in which the prescaler is at terminal count and index = NUM_DIGITS-1.
  - Frame period is NUM_DIGITS*REFRESH_DIV cycles.
- load=1: shadow <= {bcd_in, dp_in}; pending <= 1.
  - Several loads within one frame: the last one wins.
- Display update only on the frame_done cycle: if pending, display <= shadow and pending <= 0. No mid-frame tearing.
  - If load and frame_done coincide, display takes bcd_in/dp_in directly in that cycle and pending is left 0.
- Outputs are registered with 1-cycle latency from index/display. Each digit is therefore active for exactly REFRESH_DIV consecutive cycles.
- Decode (active-high, a..g):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - HEX_MODE=1: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - HEX_MODE=0: codes 10..15 = 0000000.
- Leading-zero blanking: when blank_lz=1, digit i>0 shows 0000000 if digits i..NUM_DIGITS-1 of display are all zero.
  - Digit 0 is never blanked.
  - dp still follows display dp bit.
- enable=0: on the next edge outputs go to the OFF/inactive level and prescaler, index and frame_done are held (frame_done=0).
  - load still captures into shadow.
  - On re-enable, scanning resumes from the held index and prescaler.
- Polarity inversion is applied last, to the registered outputs only.
- NUM_DIGITS=1: index stays 0 and frame_done pulses every REFRESH_DIV cycles.

Test Plan:
1. Reset, NUM_DIGITS=4, REFRESH_DIV=4, enable=1, load bcd_in=16'h1234 before the first frame end → after the first frame_done, digit_sel cycles 0001,0010,0100,1000 for 4 cycles each; segment shows 4=0110011, 3=1111001, 2=1101101, 1=0110000 respectively; frame_done pulses every 16 cycles.
2. Load 16'h0007 with blank_lz=1 → digits 3..1 show 0000000 and digit 0 shows 1110000. Load 16'h0000 → digits 3..1 are blank and digit 0 shows 1111110.
3. HEX_MODE=0 with code 4'hA → 0000000. HEX_MODE=1 with 16'hABCF → F=1000111, C=1001110, b=0011111, A=1110111.
4. Mid-frame load of 16'h5555 while 16'h1234 is displayed → current frame is unchanged; 5=1011011 appears only after the next frame_done. Load asserted on the frame_done cycle → new value is visible in the very next frame.
5. Deassert enable mid-digit for 10 cycles → outputs are OFF and frame_done=0. Re-enable → scanning resumes from the same digit with its remaining prescaler count.
6. SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1 → digit 8 gives segment=0000000 and the active digit_sel bit = 0. Assert rst_n=0 asynchronously mid-frame → outputs go immediately to 1111111 and dp=1 (OFF), digit_sel all 1.
